// File: rtl/bus_cycle_timer.sv
// Bus cycle timer for the RTC chip's multiplexed address/data bus.
// One cycle has an address phase (phases 0-4) followed by a data phase (phases 5-9),
// for either a write or a read. Each phase lasts PHASE_CLKS clks.
//
// Ports:
//   clk, rst      system clock; synchronous active-low reset
//   start         request a cycle (sampled only in IDLE), with wr_rd/addr/wdata
//   ad_in         AD bus value from the pad (captured at the end of the read strobe)
//   ad_out/ad_oe  AD bus drive value and output enable
//   cs_n/wr_n/rd_n active-low chip select and strobes
//   a_d           0 = address phase, 1 = data phase
//   busy/done     cycle in progress / one-clk end-of-cycle pulse
//   rd_data       last value captured by a read cycle
//   c_5           phase index on the first clk of each phase, 4'hF otherwise
//
// Every output is registered from the FSM state, so the pins trail the FSM by one clk:
// a start accepted at edge k shows busy from edge k+1 and done at edge k+1+10*PHASE_CLKS.
module bus_cycle_timer #(
    parameter int unsigned PHASE_CLKS = 4,
    parameter int unsigned AW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wr_rd,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] wdata,
    input  logic [AW-1:0] ad_in,
    output logic [AW-1:0] ad_out,
    output logic          ad_oe,
    output logic          cs_n,
    output logic          wr_n,
    output logic          rd_n,
    output logic          a_d,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_data,
    output logic [3:0]    c_5
);

    localparam logic [3:0] DivLast   = 4'(PHASE_CLKS - 1);
    localparam logic [3:0] LastPhase = 4'd9;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    phase_q, phase_d;
    logic [3:0]    div_q, div_d;
    logic          wr_rd_q, wr_rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] wdata_q, wdata_d;

    logic [AW-1:0] ad_out_q, ad_out_d;
    logic          ad_oe_q, ad_oe_d;
    logic          cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;
    logic          rd_n_q, rd_n_d;
    logic          a_d_q, a_d_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] rd_data_q, rd_data_d;
    logic [3:0]    c_5_q, c_5_d;

    // Next-state: sequencing of phases and the per-phase clk divider.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        div_d   = div_q;
        wr_rd_d = wr_rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    phase_d = 4'd0;
                    div_d   = 4'd0;
                    wr_rd_d = wr_rd;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            StRun: begin
                if (div_q == DivLast) begin
                    div_d = 4'd0;
                    if (phase_q == LastPhase) begin
                        state_d = StDone;
                    end else begin
                        phase_d = phase_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from the current FSM state; registered below.
    always_comb begin
        cs_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        busy_d   = (state_q == StRun);
        done_d   = (state_q == StDone);
        c_5_d    = ((state_q == StRun) && (div_q == 4'd0)) ? phase_q : 4'hF;

        if (state_q == StRun) begin
            case (phase_q)
                4'd0, 4'd4: begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = addr_q;
                end
                4'd1, 4'd3: begin
                    cs_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = addr_q;
                end
                4'd2: begin
                    cs_n_d   = 1'b0;
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = addr_q;
                end
                4'd5, 4'd6, 4'd7, 4'd8: begin
                    a_d_d    = 1'b1;
                    cs_n_d   = (phase_q == 4'd5);
                    // Reads release the bus for the whole data phase.
                    ad_oe_d  = wr_rd_q;
                    ad_out_d = wr_rd_q ? wdata_q : '0;
                    if (phase_q == 4'd7) begin
                        wr_n_d = ~wr_rd_q;
                        rd_n_d = wr_rd_q;
                    end
                end
                default: begin
                end
            endcase
        end

        // FSM state (phase 8, div 0) is the last clk the pins show phase 7, i.e. rd_n low.
        rd_data_d = rd_data_q;
        if ((state_q == StRun) && (phase_q == 4'd8) && (div_q == 4'd0) && !wr_rd_q) begin
            rd_data_d = ad_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            phase_q   <= 4'd0;
            div_q     <= 4'd0;
            wr_rd_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ad_out_q  <= '0;
            ad_oe_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            a_d_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            c_5_q     <= 4'hF;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            wr_rd_q   <= wr_rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ad_out_q  <= ad_out_d;
            ad_oe_q   <= ad_oe_d;
            cs_n_q    <= cs_n_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
            a_d_q     <= a_d_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            c_5_q     <= c_5_d;
        end
    end

    assign ad_out  = ad_out_q;
    assign ad_oe   = ad_oe_q;
    assign cs_n    = cs_n_q;
    assign wr_n    = wr_n_q;
    assign rd_n    = rd_n_q;
    assign a_d     = a_d_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign c_5     = c_5_q;

endmodule

// File: doc/bus_cycle_timer.md
Name: bus_cycle_timer

Overview:
- Generates the multiplexed address/data bus cycle toward the RTC chip: one address phase followed by one data phase, write or read.
- Exports the 4-bit phase index c_5 that the initialization counter immediately downstream consumes. That counter counts single-clock occurrences of c_5 == 4, i.e. completed address phases.
- Sits between the command source (init sequencer / user control FSM) and the pad-level tristate buffer.

Parameters:
- PHASE_CLKS, 4, clk cycles per bus phase; legal range 1..15.
- AW, 8, width of the bus word (address and data share the AD bus).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request a bus cycle; sampled only in IDLE.
- wr_rd  in  1  1 = write cycle, 0 = read cycle; sampled with start.
- addr  in  AW  register address; sampled with start.
- wdata  in  AW  write data; sampled with start.
- ad_in  in  AW  AD bus value from pad.
- ad_out  out  AW  value driven on AD bus.
- ad_oe  out  1  AD bus output enable (1 = drive).
- cs_n  out  1  chip select, active-low.
- wr_n  out  1  write strobe, active-low.
- rd_n  out  1  read strobe, active-low.
- a_d  out  1  0 = address phase, 1 = data phase.
- busy  out  1  bus cycle in progress.
- done  out  1  one-clk pulse at cycle end.
- rd_data  out  AW  data captured in a read cycle.
- c_5  out  4  phase index, valid one clk per phase; 4'hF otherwise.

Behaviour:
Reset (rst=0 at posedge) applies regardless of state, including mid-cycle:
- cs_n = wr_n = rd_n = 1; a_d = 0; ad_oe = 0; ad_out = 0; busy = 0; done = 0; rd_data = 0; c_5 = 4'hF.
- FSM returns to IDLE; the phase counter and clk-divider clear.

FSM and timing:
- States: IDLE, RUN (phase 0..9), DONE.
- IDLE: when start = 1 at edge k, latch wr_rd, addr and wdata. Enter RUN phase 0 at k+1 with busy = 1.
- start while busy or in DONE is ignored; it is not queued.
- Each phase lasts exactly PHASE_CLKS clks, counted by a 4-bit divider. Phase p+1 begins the clk after the divider reaches PHASE_CLKS-1.
- c_5 = p on the first clk of phase p only; 4'hF on all other clks and in IDLE/DONE. So c_5 == 4 is exactly one clk per bus cycle.

Outputs are registered and decoded from the phase:
- 0: setup; cs_n = 1, a_d = 0, ad_oe = 1, ad_out = addr.
- 1: cs_n = 0.
- 2: wr_n = 0 (address write).
- 3: wr_n = 1.
- 4: cs_n = 1; address phase complete.
- 5: a_d = 1. Write: ad_oe = 1, ad_out = wdata. Read: ad_oe = 0.
- 6: cs_n = 0.
- 7: strobe phase; write: wr_n = 0, read: rd_n = 0.
- 8: strobes high. Read: rd_data <= ad_in on the last clk of phase 7.
- 9: cs_n = 1, ad_oe = 0, a_d = 0.
- DONE: one clk; done = 1, busy = 0. Then IDLE.

Ordering and bus rules:
- Total latency: done at edge k + 1 + 10*PHASE_CLKS (k+41 for default).
- start may be high in the DONE clk; it is ignored. A new cycle begins earliest on the clk after DONE.
- wr_n and rd_n never both low. cs_n low only in phases 1–3 and 6–8.
- ad_oe never 1 while rd_n = 0.
- rd_data holds its value until the next read capture; write cycles do not alter it.

Test Plan:
- Reset mid-cycle: rst=0 during phase 7 of a write -> next clk cs_n=wr_n=rd_n=1, ad_oe=0, busy=0, c_5=4'hF; a new start runs a full cycle normally.
- Write, PHASE_CLKS=4: start=1, wr_rd=1, addr=8'h02, wdata=8'h10 -> ad_out=02 with wr_n low in phase 2 and a_d=0; then ad_out=10 with wr_n low in phase 7 and a_d=1; done pulse exactly 41 clks after the start edge.
- Read: wr_rd=0, addr=8'h21, ad_in=8'h59 during phase 7 -> ad_oe=0 from phase 5, rd_n low only in phase 7, rd_data=8'h59 at done, wr_n high throughout the data phase.
- c_5 profile with PHASE_CLKS=3: c_5 shows 0..9 each for exactly one clk, spaced 3 clks apart, 4'hF otherwise. A downstream counter of c_5==4 sees 1 per cycle; 10 back-to-back cycles -> 10 counts.
- start=1 held continuously -> cycles repeat with exactly one DONE clk plus one IDLE clk between them. A start pulse during busy -> no extra cycle.
- PHASE_CLKS=1 -> done 11 clks after start; strobe ordering identical; no clk with wr_n=0 and rd_n=0.
